tdc_frame_sequencer: RTL and testbench

Upstream producer for the SiFH histogram builder. It fires the laser, captures TDC timestamps during a fixed shot window, and buffers up to DATA_NUM timestamps per pixel. It then replays them as the strict pixel-interleaved wrEn/data stream the builder consumes, padding missing hits and dropping excess ones. It runs ACQ_NUM acquisitions per pass and PASS_NUM passes (coarse, then fine) per frame.

---
 rtl/tdc_frame_sequencer_pkg.sv | 30 +++
 rtl/tdc_slot_buffer.sv | 93 +++++++++
 rtl/tdc_frame_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_tdc_frame_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_frame_sequencer_pkg.sv
// Shared definitions for the TDC frame sequencer: parameter defaults matching
// the SiFH histogram builder, FSM state encoding, pad value and a width helper.
package tdc_frame_sequencer_pkg;

    // Defaults mirror the builder's parameter set
    localparam int unsigned NP_DEF         = 16;
    localparam int unsigned PIXEL_NUM_DEF  = 4;
    localparam int unsigned DATA_NUM_DEF   = 4;
    localparam int unsigned ACQ_NUM_DEF    = 8;
    localparam int unsigned PASS_NUM_DEF   = 2;
    localparam int unsigned WINDOW_CYC_DEF = 64;

    // Word replayed for slots that received no hit
    localparam int unsigned PAD_VALUE = 0;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FIRE   = 3'd1;
    localparam logic [2:0] ST_WINDOW = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Index width for a range of n values, never below one bit
    function automatic int unsigned idx_w(input int unsigned n);
        if (n > 1) return $clog2(n);
        return 1;
    endfunction

endpackage

// File: rtl/tdc_slot_buffer.sv
// Per-pixel timestamp store: PIXEL_NUM x DATA_NUM words plus a fill count per pixel.
// Ports:
//   clk, i_res        clock, synchronous active-high reset (clears fill counts)
//   i_clear           clear all fill counts (start of acquisition)
//   i_wr_valid        write request for pixel i_wr_pixel with i_wr_data
//   o_wr_accept_c     request is accepted (pixel in range and not full)
//   i_rd_pixel/slot   read address
//   o_rd_data_c       stored word, or pad when slot >= fill; sees a same-cycle write
module tdc_slot_buffer
    import tdc_frame_sequencer_pkg::*;
#(
    parameter int unsigned NP        = NP_DEF,
    parameter int unsigned PIXEL_NUM = PIXEL_NUM_DEF,
    parameter int unsigned DATA_NUM  = DATA_NUM_DEF
) (
    input  logic                          clk,
    input  logic                          i_res,
    input  logic                          i_clear,
    input  logic                          i_wr_valid,
    input  logic [idx_w(PIXEL_NUM)-1:0]   i_wr_pixel,
    input  logic [NP-1:0]                 i_wr_data,
    output logic                          o_wr_accept_c,
    input  logic [idx_w(PIXEL_NUM)-1:0]   i_rd_pixel,
    input  logic [idx_w(DATA_NUM)-1:0]    i_rd_slot,
    output logic [NP-1:0]                 o_rd_data_c
);

    localparam int unsigned PIX_W  = idx_w(PIXEL_NUM);
    localparam int unsigned SLOT_W = idx_w(DATA_NUM);
    localparam int unsigned FILL_W = $clog2(DATA_NUM + 1);

    logic [NP-1:0]     r_mem  [PIXEL_NUM][DATA_NUM];
    logic [FILL_W-1:0] r_fill [PIXEL_NUM];

    logic [PIXEL_NUM-1:0] w_wr_sel;
    logic                 w_accept;
    logic [FILL_W-1:0]    w_fill_sel;
    logic [NP-1:0]        w_mem_sel;
    logic                 w_fwd;

    // Write decode; an out-of-range pixel selects nothing and is rejected
    always_comb begin
        w_wr_sel = '0;
        for (int p = 0; p < PIXEL_NUM; p++) begin
            w_wr_sel[p] = i_wr_valid && (i_wr_pixel == PIX_W'(p))
                          && (r_fill[p] < FILL_W'(DATA_NUM));
        end
    end

    assign w_accept      = |w_wr_sel;
    assign o_wr_accept_c = w_accept;

    // Fill counters
    always_ff @(posedge clk) begin
        if (i_res || i_clear) begin
            for (int p = 0; p < PIXEL_NUM; p++) r_fill[p] <= '0;
        end else begin
            for (int p = 0; p < PIXEL_NUM; p++) begin
                if (w_wr_sel[p]) r_fill[p] <= r_fill[p] + FILL_W'(1);
            end
        end
    end

    // Slot storage; contents are only visible below the fill count, so no reset
    always_ff @(posedge clk) begin
        for (int p = 0; p < PIXEL_NUM; p++) begin
            if (w_wr_sel[p]) r_mem[p][SLOT_W'(r_fill[p])] <= i_wr_data;
        end
    end

    // Read with pad; forwarding covers a hit landing on the slot read this cycle
    always_comb begin
        w_fill_sel  = '0;
        w_mem_sel   = '0;
        o_rd_data_c = NP'(PAD_VALUE);
        for (int p = 0; p < PIXEL_NUM; p++) begin
            if (i_rd_pixel == PIX_W'(p)) begin
                w_fill_sel = r_fill[p];
                for (int s = 0; s < DATA_NUM; s++) begin
                    if (i_rd_slot == SLOT_W'(s)) w_mem_sel = r_mem[p][s];
                end
            end
        end
        w_fwd = w_accept && (i_wr_pixel == i_rd_pixel)
                && (w_fill_sel == FILL_W'(i_rd_slot));
        if (w_fwd) begin
            o_rd_data_c = i_wr_data;
        end else if (FILL_W'(i_rd_slot) < w_fill_sel) begin
            o_rd_data_c = w_mem_sel;
        end
    end

endmodule

// File: rtl/tdc_frame_sequencer.sv
// Fires the laser, captures TDC hits per pixel during a shot window, then replays
// them as a pixel-interleaved wrEn/data stream for the histogram builder.
// Ports:
//   clk, res            clock, synchronous active-high reset
//   start               frame start request (IDLE only)
//   busy                high outside IDLE
//   laser_fire          one-cycle pulse per acquisition
//   tdc_valid/pixel/data  timestamp input
//   wrEn, data          builder write stream
//   pass_idx            current pass, 0 = coarse
//   frame_done          pulse one cycle after the final word
//   drop_cnt            saturating count of rejected hits
module tdc_frame_sequencer
    import tdc_frame_sequencer_pkg::*;
#(
    parameter int unsigned NP         = NP_DEF,
    parameter int unsigned PIXEL_NUM  = PIXEL_NUM_DEF,
    parameter int unsigned DATA_NUM   = DATA_NUM_DEF,
    parameter int unsigned ACQ_NUM    = ACQ_NUM_DEF,
    parameter int unsigned PASS_NUM   = PASS_NUM_DEF,
    parameter int unsigned WINDOW_CYC = WINDOW_CYC_DEF
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic                          start,
    output logic                          busy,
    output logic                          laser_fire,
    input  logic                          tdc_valid,
    input  logic [idx_w(PIXEL_NUM)-1:0]   tdc_pixel,
    input  logic [NP-1:0]                 tdc_data,
    output logic                          wrEn,
    output logic [NP-1:0]                 data,
    output logic [idx_w(PASS_NUM)-1:0]    pass_idx,
    output logic                          frame_done,
    output logic [15:0]                   drop_cnt
);

    localparam int unsigned PIX_W     = idx_w(PIXEL_NUM);
    localparam int unsigned SLOT_W    = idx_w(DATA_NUM);
    localparam int unsigned ACQ_W     = idx_w(ACQ_NUM);
    localparam int unsigned PASS_W    = idx_w(PASS_NUM);
    localparam int unsigned DRAIN_CYC = PIXEL_NUM * DATA_NUM;
    localparam int unsigned CYC_MAX   = (WINDOW_CYC > DRAIN_CYC) ? WINDOW_CYC : DRAIN_CYC;
    localparam int unsigned CYC_W     = idx_w(CYC_MAX);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CYC_W-1:0]    r_cyc_cnt;
    logic [ACQ_W-1:0]    r_acq_cnt;
    logic [PASS_W-1:0]   r_pass_idx;
    logic [15:0]         r_drop_cnt;
    logic [PIX_W-1:0]    r_rd_pixel;
    logic [SLOT_W-1:0]   r_rd_slot;
    logic                r_busy;
    logic                r_laser_fire;
    logic                r_wr_en;
    logic [NP-1:0]       r_data;
    logic                r_frame_done;

    logic                w_win_last;
    logic                w_drain_last;
    logic                w_acq_last;
    logic                w_pass_last;
    logic                w_drain_end;
    logic                w_wr_valid;
    logic                w_accept;
    logic                w_load;
    logic [NP-1:0]       w_rd_data;

    assign w_win_last   = (r_cyc_cnt == CYC_W'(WINDOW_CYC - 1));
    assign w_drain_last = (r_cyc_cnt == CYC_W'(DRAIN_CYC - 1));
    assign w_acq_last   = (r_acq_cnt == ACQ_W'(ACQ_NUM - 1));
    assign w_pass_last  = (r_pass_idx == PASS_W'(PASS_NUM - 1));
    assign w_drain_end  = (r_state == ST_DRAIN) && w_drain_last;
    assign w_wr_valid   = (r_state == ST_WINDOW) && tdc_valid;
    // A word is loaded into the output register the cycle before it is shown
    assign w_load       = (w_state_nxt == ST_DRAIN);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_FIRE;
            ST_FIRE:   w_state_nxt = ST_WINDOW;
            ST_WINDOW: if (w_win_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (w_drain_last) w_state_nxt = (w_acq_last && w_pass_last) ? ST_DONE : ST_FIRE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (res) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Cycle counter for WINDOW and DRAIN, restarted on every state change
    always_ff @(posedge clk) begin
        if (res || (w_state_nxt != r_state)) begin
            r_cyc_cnt <= '0;
        end else if ((r_state == ST_WINDOW) || (r_state == ST_DRAIN)) begin
            r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
        end
    end

    // Acquisition / pass counters and drop counter
    always_ff @(posedge clk) begin
        if (res) begin
            r_acq_cnt  <= '0;
            r_pass_idx <= '0;
            r_drop_cnt <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_acq_cnt  <= '0;
            r_pass_idx <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_drain_end) begin
                if (!w_acq_last) begin
                    r_acq_cnt <= r_acq_cnt + ACQ_W'(1);
                end else if (!w_pass_last) begin
                    r_pass_idx <= r_pass_idx + PASS_W'(1);
                    r_acq_cnt  <= '0;
                end
            end
            if (w_wr_valid && !w_accept && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // Drain read pointer, pixel-major
    always_ff @(posedge clk) begin
        if (res || (r_state == ST_FIRE)) begin
            r_rd_pixel <= '0;
            r_rd_slot  <= '0;
        end else if (w_load) begin
            if (r_rd_slot == SLOT_W'(DATA_NUM - 1)) begin
                r_rd_slot  <= '0;
                r_rd_pixel <= r_rd_pixel + PIX_W'(1);
            end else begin
                r_rd_slot <= r_rd_slot + SLOT_W'(1);
            end
        end
    end

    // Registered outputs, derived from the state being entered
    always_ff @(posedge clk) begin
        if (res) begin
            r_busy       <= 1'b0;
            r_laser_fire <= 1'b0;
            r_wr_en      <= 1'b0;
            r_data       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_laser_fire <= (w_state_nxt == ST_FIRE);
            r_wr_en      <= w_load;
            r_data       <= w_load ? w_rd_data : NP'(PAD_VALUE);
            r_frame_done <= (w_state_nxt == ST_DONE);
        end
    end

    tdc_slot_buffer #(
        .NP        (NP),
        .PIXEL_NUM (PIXEL_NUM),
        .DATA_NUM  (DATA_NUM)
    ) u_slot_buffer (
        .clk           (clk),
        .i_res         (res),
        .i_clear       (r_state == ST_FIRE),
        .i_wr_valid    (w_wr_valid),
        .i_wr_pixel    (tdc_pixel),
        .i_wr_data     (tdc_data),
        .o_wr_accept_c (w_accept),
        .i_rd_pixel    (r_rd_pixel),
        .i_rd_slot     (r_rd_slot),
        .o_rd_data_c   (w_rd_data)
    );

    assign busy       = r_busy;
    assign laser_fire = r_laser_fire;
    assign wrEn       = r_wr_en;
    assign data       = r_data;
    assign pass_idx   = r_pass_idx;
    assign frame_done = r_frame_done;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_tdc_frame_sequencer.sv
// Testbench for tdc_frame_sequencer: default-parameter instance driven with
// directed and random hits against a per-pixel list model, plus a small
// PIXEL_NUM=3 instance where an out-of-range pixel index is representable.
module tb_tdc_frame_sequencer;

    localparam int unsigned PN     = 4;
    localparam int unsigned DN     = 4;
    localparam int unsigned ACQ    = 8;
    localparam int unsigned PASSES = 2;
    localparam int unsigned WIN    = 64;
    localparam int unsigned WORDS  = PN * DN;

    logic        clk;
    logic        res;
    logic        start;
    logic        busy;
    logic        laser_fire;
    logic        tdc_valid;
    logic [1:0]  tdc_pixel;
    logic [15:0] tdc_data;
    logic        wrEn;
    logic [15:0] data;
    logic [0:0]  pass_idx;
    logic        frame_done;
    logic [15:0] drop_cnt;

    // Second instance: 3 pixels x 2 words, 4-cycle window, single acquisition
    logic        start2;
    logic        busy2;
    logic        laser2;
    logic        valid2;
    logic [1:0]  pixel2;
    logic [15:0] tdata2;
    logic        wr2;
    logic [15:0] data2;
    logic [0:0]  pass2;
    logic        done2;
    logic [15:0] drop2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int n_fire, n_wr, n_done, last_wr_cyc;

    int          exp_fill [PN];
    logic [15:0] exp_slot [PN][DN];
    int          exp_drop;

    tdc_frame_sequencer dut (
        .clk(clk), .res(res), .start(start), .busy(busy), .laser_fire(laser_fire),
        .tdc_valid(tdc_valid), .tdc_pixel(tdc_pixel), .tdc_data(tdc_data),
        .wrEn(wrEn), .data(data), .pass_idx(pass_idx), .frame_done(frame_done),
        .drop_cnt(drop_cnt)
    );

    tdc_frame_sequencer #(
        .NP(16), .PIXEL_NUM(3), .DATA_NUM(2), .ACQ_NUM(1), .PASS_NUM(1), .WINDOW_CYC(4)
    ) dut2 (
        .clk(clk), .res(res), .start(start2), .busy(busy2), .laser_fire(laser2),
        .tdc_valid(valid2), .tdc_pixel(pixel2), .tdc_data(tdata2),
        .wrEn(wr2), .data(data2), .pass_idx(pass2), .frame_done(done2),
        .drop_cnt(drop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the middle of the next cycle and tally stream events
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (wrEn === 1'b1) begin
            n_wr++;
            last_wr_cyc = cyc;
        end
        if (laser_fire === 1'b1) n_fire++;
        if (frame_done === 1'b1) n_done++;
    endtask

    // Reference: each pixel keeps its first DN hits in arrival order
    task automatic hit(input int p, input logic [15:0] d);
        tdc_valid = 1'b1;
        tdc_pixel = 2'(p);
        tdc_data  = d;
        if (p < PN && exp_fill[p] < DN) begin
            exp_slot[p][exp_fill[p]] = d;
            exp_fill[p]++;
        end else if (exp_drop < 65535) begin
            exp_drop++;
        end
    endtask

    function automatic logic [15:0] exp_word(input int i);
        int p;
        int s;
        p = i / DN;
        s = i % DN;
        return (s < exp_fill[p]) ? exp_slot[p][s] : 16'h0000;
    endfunction

    // Random strobes outside the window must be ignored
    task automatic noise(input bit en);
        tdc_valid = en && ($urandom_range(0, 1) == 1);
        tdc_pixel = 2'($urandom_range(0, 3));
        tdc_data  = 16'($urandom);
    endtask

    function automatic int pick(input int fmode, input int idx);
        case (fmode)
            0: return 0;
            1: return (idx == 0) ? 1 : (idx == 1) ? 2 : (idx == 2) ? 4 : 3;
            2: return 2;
            default: return 3;
        endcase
    endfunction

    // One acquisition, entered at the middle of its FIRE cycle
    task automatic run_acq(input int mode, input int exp_pass, input int abort_word,
                           output bit aborted);
        aborted = 1'b0;
        check("fire_pulse", 32'(laser_fire), 1);
        check("fire_busy", 32'(busy), 1);
        check("fire_wren", 32'(wrEn), 0);
        check("fire_pass", 32'(pass_idx), 32'(exp_pass));
        for (int p = 0; p < PN; p++) exp_fill[p] = 0;
        noise(mode == 3);
        for (int k = 0; k < WIN; k++) begin
            tick();
            if (k == 0 || k == WIN - 1) begin
                check("win_laser", 32'(laser_fire), 0);
                check("win_wren", 32'(wrEn), 0);
            end
            tdc_valid = 1'b0;
            start     = 1'b0;
            case (mode)
                1: if (k % 8 == 3 && k / 8 < PN) hit(k / 8, 16'h1000 + 16'(k / 8));
                2: if (k >= 10 && k < 16) hit(2, 16'h2000 + 16'(k));
                3: begin
                    if (k == WIN - 1 || $urandom_range(0, 2) == 0)
                        hit(int'($urandom_range(0, PN - 1)), 16'($urandom));
                    start = ($urandom_range(0, 7) == 0);
                end
                4: if (k == WIN - 1) hit(0, 16'hBEEF);
                default: ;
            endcase
        end
        tick();
        start = 1'b0;
        noise(mode == 3);
        check("drain_drop", 32'(drop_cnt), 32'(exp_drop));
        for (int i = 0; i < WORDS; i++) begin
            if (i > 0) begin
                tick();
                noise(mode == 3);
            end
            check("drain_wren", 32'(wrEn), 1);
            check("drain_data", 32'(data), 32'(exp_word(i)));
            check("drain_pass", 32'(pass_idx), 32'(exp_pass));
            if (i == abort_word) begin
                res     = 1'b1;
                aborted = 1'b1;
                tdc_valid = 1'b0;
                return;
            end
        end
        tdc_valid = 1'b0;
    endtask

    // Whole frame from IDLE; returns early (reset asserted) if aborted
    task automatic run_frame(input int fmode, input int abort_acq, output bit aborted);
        int idx;
        n_fire   = 0;
        n_wr     = 0;
        n_done   = 0;
        exp_drop = 0;
        aborted  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int ps = 0; ps < PASSES; ps++) begin
            for (int a = 0; a < ACQ; a++) begin
                idx = ps * ACQ + a;
                run_acq(pick(fmode, idx), ps, (idx == abort_acq) ? 5 : -1, aborted);
                if (aborted) return;
                tick();
            end
        end
        check("done_pulse", 32'(frame_done), 1);
        check("done_wren", 32'(wrEn), 0);
        check("done_gap", 32'(cyc - last_wr_cyc), 1);
        tick();
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(frame_done), 0);
        check("frame_fires", 32'(n_fire), PASSES * ACQ);
        check("frame_words", 32'(n_wr), PASSES * ACQ * WORDS);
        check("frame_dones", 32'(n_done), 1);
        check("frame_drop", 32'(drop_cnt), 32'(exp_drop));
    endtask

    initial begin
        bit ab;
        logic [15:0] d2_exp [6];
        int          d2_pix [4];
        logic [15:0] d2_dat [4];

        res = 1'b1; start = 1'b0; tdc_valid = 1'b0; tdc_pixel = '0; tdc_data = '0;
        start2 = 1'b0; valid2 = 1'b0; pixel2 = '0; tdata2 = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_laser", 32'(laser_fire), 0);
        check("rst_wren", 32'(wrEn), 0);
        check("rst_data", 32'(data), 0);
        check("rst_pass", 32'(pass_idx), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        check("rst_busy2", 32'(busy2), 0);
        res = 1'b0;
        tick();

        // Directed acquisitions, last-cycle hit, then random with stray starts
        run_frame(1, -1, ab);
        // No hits at all
        run_frame(0, -1, ab);
        // Reset in the middle of the first drain
        run_frame(2, 0, ab);
        check("abort_taken", 32'(ab), 1);
        tick();
        check("abort_busy", 32'(busy), 0);
        check("abort_laser", 32'(laser_fire), 0);
        check("abort_wren", 32'(wrEn), 0);
        check("abort_data", 32'(data), 0);
        check("abort_pass", 32'(pass_idx), 0);
        check("abort_done", 32'(frame_done), 0);
        check("abort_drop", 32'(drop_cnt), 0);
        res = 1'b0;
        tick();
        check("abort_idle", 32'(busy), 0);
        run_frame(3, -1, ab);

        // Out-of-range pixel needs a non-power-of-two pixel count to be expressible
        d2_pix = '{3, 0, 2, 3};
        d2_dat = '{16'h1111, 16'hAAAA, 16'hBBBB, 16'h2222};
        d2_exp = '{16'hAAAA, 16'h0000, 16'h0000, 16'h0000, 16'hBBBB, 16'h0000};
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("d2_fire", 32'(laser2), 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            valid2 = 1'b1;
            pixel2 = 2'(d2_pix[k]);
            tdata2 = d2_dat[k];
        end
        tick();
        pixel2 = 2'd3;
        tdata2 = 16'h3333;
        check("d2_drop", 32'(drop2), 2);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            check("d2_wren", 32'(wr2), 1);
            check("d2_data", 32'(data2), 32'(d2_exp[i]));
        end
        tick();
        valid2 = 1'b0;
        check("d2_done", 32'(done2), 1);
        check("d2_wren_off", 32'(wr2), 0);
        tick();
        check("d2_drop_final", 32'(drop2), 2);
        check("d2_idle", 32'(busy2), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
